// File: rtl/pulse_sequencer_pkg.sv
// Shared types and helpers for the pulse sequencer.
// Optional looping mode is enabled by defining PULSE_SEQ_LOOP_EN.
package pulse_seq_pkg;

  localparam int unsigned PSEQ_CNT_W = 8;
  localparam int unsigned PSEQ_REP_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  function automatic int unsigned max1(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

endpackage

// File: rtl/pulse_sequencer_if.sv
// Host-side bundle of the pulse sequencer: request, config and status.
// The loop input exists only when PULSE_SEQ_LOOP_EN is defined.
interface pulse_sequencer_if
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W = PSEQ_CNT_W,
  parameter int unsigned REP_W = PSEQ_REP_W
) ();

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] delay_cyc;
  logic [CNT_W-1:0] high_cyc;
  logic [CNT_W-1:0] low_cyc;
  logic [REP_W-1:0] repeat_n;
`ifdef PULSE_SEQ_LOOP_EN
  logic             loop;
`endif
  logic             a;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] pulse_cnt;

  modport master (
    output start, abort, delay_cyc, high_cyc, low_cyc, repeat_n,
`ifdef PULSE_SEQ_LOOP_EN
    output loop,
`endif
    input  a, busy, done, pulse_cnt
  );

  modport slave (
    input  start, abort, delay_cyc, high_cyc, low_cyc, repeat_n,
`ifdef PULSE_SEQ_LOOP_EN
    input  loop,
`endif
    output a, busy, done, pulse_cnt
  );

endinterface

// File: rtl/pulse_sequencer_seq_down_counter.sv
// Loadable saturating down-counter used as the phase timer.
module seq_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Programmable pulse-train generator driving dut.a, with busy/done status.
// Define PULSE_SEQ_LOOP_EN to add the loop input for endless repetition.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W = PSEQ_CNT_W,
  parameter int unsigned REP_W = PSEQ_REP_W
) (
  input  logic              clk,
  input  logic              reset,
  pulse_sequencer_if.slave  seq_if
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] pcnt_q, pcnt_d;
  logic             a_q, a_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             go_delay;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  // Phase timer holds (length - 1); zero-length phases are stretched to one cycle.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] x);
    return CNT_W'(max1(32'(x)) - 1);
  endfunction

  seq_down_counter #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (state_q != S_IDLE),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    go_delay = 1'b0;
`ifdef PULSE_SEQ_LOOP_EN
    go_delay = wrap_q && (delay_q != '0);
`endif
  end

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    high_d   = high_q;
    low_d    = low_q;
    rep_d    = rep_q;
    pcnt_d   = pcnt_q;
    wrap_d   = wrap_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if ((state_q != S_IDLE) && seq_if.abort) begin
      state_d = S_IDLE;
      wrap_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (seq_if.start && !seq_if.abort) begin
            delay_d = seq_if.delay_cyc;
            high_d  = seq_if.high_cyc;
            low_d   = seq_if.low_cyc;
            rep_d   = seq_if.repeat_n;
            pcnt_d  = '0;
            wrap_d  = 1'b0;
            if (seq_if.repeat_n == '0) begin
              state_d = S_DONE;
            end else if (seq_if.delay_cyc != '0) begin
              state_d  = S_DELAY;
              tmr_load = 1'b1;
              tmr_val  = seq_if.delay_cyc - CNT_W'(1);
            end else begin
              state_d  = S_HIGH;
              tmr_load = 1'b1;
              tmr_val  = phase_load(seq_if.high_cyc);
              pcnt_d   = REP_W'(1);
            end
          end
        end
        S_DELAY: begin
          if (tmr_zero) begin
            state_d  = S_HIGH;
            tmr_load = 1'b1;
            tmr_val  = phase_load(high_q);
            pcnt_d   = pcnt_q + REP_W'(1);
          end
        end
        S_HIGH: begin
          if (tmr_zero) begin
            if (pcnt_q < rep_q) begin
              state_d  = S_LOW;
              tmr_load = 1'b1;
              tmr_val  = phase_load(low_q);
            end else begin
              state_d = S_DONE;
`ifdef PULSE_SEQ_LOOP_EN
              if (seq_if.loop) begin
                state_d  = S_LOW;
                tmr_load = 1'b1;
                tmr_val  = phase_load(low_q);
                pcnt_d   = '0;
                wrap_d   = 1'b1;
              end
`endif
            end
          end
        end
        S_LOW: begin
          if (tmr_zero) begin
            wrap_d   = 1'b0;
            tmr_load = 1'b1;
            if (go_delay) begin
              state_d = S_DELAY;
              tmr_val = delay_q - CNT_W'(1);
            end else begin
              state_d = S_HIGH;
              tmr_val = phase_load(high_q);
              pcnt_d  = pcnt_q + REP_W'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they appear registered with it.
  always_comb begin
    a_d    = (state_d == S_HIGH);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      delay_q <= '0;
      high_q  <= '0;
      low_q   <= '0;
      rep_q   <= '0;
      pcnt_q  <= '0;
      wrap_q  <= 1'b0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      high_q  <= high_d;
      low_q   <= low_d;
      rep_q   <= rep_d;
      pcnt_q  <= pcnt_d;
      wrap_q  <= wrap_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign seq_if.a         = a_q;
  assign seq_if.busy      = busy_q;
  assign seq_if.done      = done_q;
  assign seq_if.pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer: directed cases plus random traffic
// compared against a closed-form timeline model of each sequence.
module tb_pulse_sequencer;
  import pulse_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pulse_sequencer_if #(.CNT_W(8), .REP_W(4)) seq_if ();

  pulse_sequencer #(.CNT_W(8), .REP_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .seq_if (seq_if)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  bit m_active = 1'b0;
  int m_k, m_D, m_H, m_L, m_N;
  int m_pc_hold = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int t_done();
    if (m_N == 0) return 1;
    return m_D + m_N * m_H + (m_N - 1) * m_L + 1;
  endfunction

  function automatic int exp_a(input int t);
    int p0, per;
    if (m_N == 0) return 0;
    p0  = m_D + 1;
    per = m_H + m_L;
    if (t < p0) return 0;
    if ((t - p0) / per >= m_N) return 0;
    return (((t - p0) % per) < m_H) ? 1 : 0;
  endfunction

  function automatic int exp_pc(input int t);
    int p0, n;
    if (m_N == 0) return 0;
    p0 = m_D + 1;
    if (t < p0) return 0;
    n = (t - p0) / (m_H + m_L) + 1;
    return (n > m_N) ? m_N : n;
  endfunction

  task automatic model_edge();
    int  t;
    bit  was_active;
    was_active = m_active;
    if (m_active) begin
      t = edge_n - m_k;
      if (seq_if.abort) begin
        m_pc_hold = exp_pc(t);
        m_active  = 1'b0;
      end else if (t == t_done()) begin
        m_pc_hold = m_N;
        m_active  = 1'b0;
      end
    end
    if (!was_active && seq_if.start && !seq_if.abort) begin
      m_active  = 1'b1;
      m_k       = edge_n;
      m_D       = int'(seq_if.delay_cyc);
      m_H       = int'(max1(32'(seq_if.high_cyc)));
      m_L       = int'(max1(32'(seq_if.low_cyc)));
      m_N       = int'(seq_if.repeat_n);
      m_pc_hold = 0;
    end
    edge_n++;
  endtask

  task automatic check_outputs();
    int t, ea, eb, ed, ep;
    if (m_active) begin
      t  = edge_n - m_k;
      ea = exp_a(t);
      eb = 1;
      ed = (t == t_done()) ? 1 : 0;
      ep = exp_pc(t);
    end else begin
      ea = 0; eb = 0; ed = 0; ep = m_pc_hold;
    end
    chk("a",         int'(seq_if.a),         ea);
    chk("busy",      int'(seq_if.busy),      eb);
    chk("done",      int'(seq_if.done),      ed);
    chk("pulse_cnt", int'(seq_if.pulse_cnt), ep);
  endtask

  task automatic run_cycle(input bit st, input bit ab);
    seq_if.start = st;
    seq_if.abort = ab;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    seq_if.start = 1'b0;
    seq_if.abort = 1'b0;
  endtask

  task automatic set_cfg(input int d, input int h, input int l, input int n);
    seq_if.delay_cyc = 8'(d);
    seq_if.high_cyc  = 8'(h);
    seq_if.low_cyc   = 8'(l);
    seq_if.repeat_n  = 4'(n);
  endtask

  task automatic scramble_cfg();
    set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
    if ($urandom_range(0, 9) == 0) seq_if.delay_cyc = 8'($urandom_range(5, 20));
  endtask

  // Start a sequence, then run 'cycles' more edges; config inputs are scrambled
  // while busy, with optional extra start and abort at given cycle offsets.
  task automatic run_seq(input int d, input int h, input int l, input int n,
                         input int cycles, input int abort_at, input int noise_at);
    set_cfg(d, h, l, n);
    run_cycle(1'b1, 1'b0);
    scramble_cfg();
    for (int i = 1; i <= cycles; i++) begin
      run_cycle(i == noise_at, i == abort_at);
    end
  endtask

  task automatic do_reset_mid();
    #3 reset = 1'b0;
    #1;
    chk("rst_a",    int'(seq_if.a),         0);
    chk("rst_busy", int'(seq_if.busy),      0);
    chk("rst_done", int'(seq_if.done),      0);
    chk("rst_pcnt", int'(seq_if.pulse_cnt), 0);
    m_active  = 1'b0;
    m_pc_hold = 0;
    repeat (2) begin
      @(posedge clk);
      edge_n++;
      #1;
      check_outputs();
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    seq_if.start = 1'b0;
    seq_if.abort = 1'b0;
    set_cfg(0, 0, 0, 0);
`ifdef PULSE_SEQ_LOOP_EN
    seq_if.loop = 1'b0;
`endif
    #2;
    check_outputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) run_cycle(1'b0, 1'b0);

    // delay=2 high=3 low=2 repeat=2; stray start while busy must be ignored
    run_seq(2, 3, 2, 2, 14, 0, 4);
    chk("basic_pcnt", int'(seq_if.pulse_cnt), 2);

    run_seq(0, 0, 0, 3, 8, 0, 0);
    chk("zero_pcnt", int'(seq_if.pulse_cnt), 3);

    run_seq(3, 2, 2, 0, 4, 0, 0);
    chk("rep0_pcnt", int'(seq_if.pulse_cnt), 0);

    // abort lands in the second LOW phase
    run_seq(1, 2, 3, 4, 14, 10, 0);
    chk("abort_pcnt", int'(seq_if.pulse_cnt), 2);

    set_cfg(1, 1, 1, 2);
    run_cycle(1'b1, 1'b1);
    chk("start_abort_busy", int'(seq_if.busy), 0);
    repeat (3) run_cycle(1'b0, 1'b0);

    run_seq(0, 5, 1, 2, 2, 0, 0);
    chk("pre_rst_a", int'(seq_if.a), 1);
    do_reset_mid();
    repeat (4) run_cycle(1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      scramble_cfg();
      run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
